m3_stepseq: RTL and testbench
=============================

Name: m3_stepSeq

Overview:
- Parametrised commutation step sequencer for the 3-phase motor path; successor to the fixed 12-step calculator.
- Generalises step count, period range, acceleration rate and hold rounds.
- Adds an align phase, graceful braking on stop, a direction register with bidirectional stepping, and step/round strobes.
- Feeds the step index and current period to the PWM/power stage.

Parameters:
- STEPS, 12, steps per electrical round (>=2).
- STEP_W, 4, width of stepO (>= clog2(STEPS)).
- PERIOD_W, 22, period/counter width.
- PERIOD_MAX, 4000000, slowest step period in clocks; also the start and stop speed.
- PERIOD_MIN, 40, fastest step period in clocks.
- ACC_SHIFT, 4, per-update period change = period>>ACC_SHIFT (1/16).
- ROUND_HOLD, 3, consecutive request rounds before each speed change.

Ports:
- clkI  in  1  clock
- rstI  in  1  asynchronous reset, active-high
- startI  in  1  level; 1 = run, 0 = brake to stop
- forceStopI  in  1  level; immediate stop, highest priority
- invRotateI  in  1  requested direction (1 = reverse)
- speedINCi  in  1  request shorter period
- speedDECi  in  1  request longer period
- stepO  out  STEP_W  current step index 0..STEPS-1
- stepStbO  out  1  one-cycle pulse on every step advance
- roundStbO  out  1  one-cycle pulse on round boundary, coincident with stepStbO
- periodO  out  PERIOD_W  current step period
- stateO  out  2  0 IDLE, 1 ALIGN, 2 RUN, 3 BRAKE
- workingO  out  1  state != IDLE
- dirO  out  1  applied direction

Behaviour:
- Reset (rstI=1, async): state IDLE; stepO=0; stepStbO=roundStbO=0; periodO=PERIOD_MAX; remain=PERIOD_MAX; holdCnt=ROUND_HOLD; lastReq=INC; dirO=0; workingO=0.
- forceStopI=1 in any state: next edge applies the reset values except dirO, which is held; no strobes. This overrides startI.
- IDLE: counters are held. When startI=1 and forceStopI=0: go to ALIGN, remain=PERIOD_MAX, dirO<=invRotateI.
- Step timer (ALIGN/RUN/BRAKE): remain decrements by 1 each cycle. When remain==1:
  - stepStbO=1 for that cycle.
  - stepO advances:
    - forward: +1, with STEPS-1 -> 0.
    - reverse: -1, with 0 -> STEPS-1.
  - remain reloads with the period value being written that same cycle (an updated period takes effect on the first step of the new round).
- ALIGN:
  - stepO=0 for exactly PERIOD_MAX cycles.
  - On its strobe, go to RUN; stepO becomes 1 (fwd) or STEPS-1 (rev).
  - No roundStbO; no speed update.
- Round boundary (RUN/BRAKE only): a strobe that steps off STEPS-1 (fwd) or off 0 (rev). roundStbO=1 on that cycle.
- RUN speed update, at round boundary only:
  - speedINCi=1 (INC wins if both are set):
    - If lastReq==DEC: lastReq<=INC, holdCnt<=ROUND_HOLD, no period change.
    - Else if holdCnt!=0: holdCnt-1.
    - Else: holdCnt<=ROUND_HOLD, period<=max(period-d, PERIOD_MIN).
  - speedDECi=1 alone: mirror of the above, with period<=min(period+d, PERIOD_MAX).
  - Neither request: holdCnt<=ROUND_HOLD.
  - Delta: d = period>>ACC_SHIFT, forced to 1 if zero. Arithmetic is done in PERIOD_W+1 bits so the add cannot overflow before the clamp.
- Direction:
  - At a RUN round boundary, dirO<=invRotateI only if periodO==PERIOD_MAX.
  - Otherwise the request is ignored; it is re-evaluated at each later boundary.
- RUN with startI=0 at any cycle: go to BRAKE on the next edge; the step timer continues.
- BRAKE, at each round boundary:
  - period<=min(period+d, PERIOD_MAX) with no hold; speed requests are ignored.
  - If the new period==PERIOD_MAX: go to IDLE at that edge, with stepO=0 and remain=PERIOD_MAX.
  - startI=1 in BRAKE: back to RUN on the next edge, keeping the current period and step; holdCnt<=ROUND_HOLD.
- Mid-operation async reset: all outputs return to their reset values immediately.
- periodO always lies in [PERIOD_MIN, PERIOD_MAX].

Test Plan (PERIOD_MAX=300, PERIOD_MIN=40, STEPS=12, ACC_SHIFT=4, ROUND_HOLD=3 unless noted):
- Start: startI=1 at t0 -> stateO=1 with stepO=0 for 300 cycles, then RUN with stepO=1. stepStbO then pulses every 300 cycles, and roundStbO pulses every 3600 cycles on the 11->0 step.
- Accelerate: speedINCi held from RUN entry -> rounds 1-3 only decrement holdCnt; at boundary 4 periodO=282 (300-18); 4 boundaries later 265. The next step interval after each update equals the new period.
- Clamp/switch: with periodO=42, INC at hold expiry -> 40, and further INC stays 40. Then DEC -> first boundary only resets holdCnt, and the period changes at boundary 5 to 42.
- Brake: periodO=282, startI->0 -> stateO=3; boundary 1 gives 299, boundary 2 clamps to 300, stateO=0, stepO=0, workingO=0. Reassert startI mid-brake at 299 -> RUN at 299.
- Reverse: invRotateI=1 before start -> after ALIGN, stepO=11,10,...; roundStbO on the 0->11 step. Toggling invRotateI while periodO=282 leaves dirO unchanged until the period returns to 300.
- Force stop/reset: forceStopI pulse mid-RUN -> IDLE next edge, periodO=300, no strobe. rstI asserted mid-step -> outputs reset asynchronously. With PERIOD_MIN=8 and a period of 10, INC applies d=1 -> 9.

Source files
------------

// File: rtl/m3_stepseq.sv
`default_nettype none
// ============================================================================
//  Module      : m3_stepseq
//  Description : Commutation step sequencer for the 3-phase motor path.
//                Align phase, ramped run with hold rounds, graceful braking,
//                bidirectional stepping, step and round strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module m3_stepseq #(
    parameter int STEPS      = 12,
    parameter int STEP_W     = 4,
    parameter int PERIOD_W   = 22,
    parameter int PERIOD_MAX = 4000000,
    parameter int PERIOD_MIN = 40,
    parameter int ACC_SHIFT  = 4,
    parameter int ROUND_HOLD = 3
) (
    input  logic                clkI,
    input  logic                rstI,
    input  logic                startI,
    input  logic                forceStopI,
    input  logic                invRotateI,
    input  logic                speedINCi,
    input  logic                speedDECi,
    output logic [STEP_W-1:0]   stepO,
    output logic                stepStbO,
    output logic                roundStbO,
    output logic [PERIOD_W-1:0] periodO,
    output logic [1:0]          stateO,
    output logic                workingO,
    output logic                dirO
);

    localparam int c_HOLD_W = (ROUND_HOLD < 1) ? 1 : $clog2(ROUND_HOLD + 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ALIGN = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;
    localparam logic [1:0] c_ST_BRAKE = 2'd3;

    localparam logic [PERIOD_W-1:0] c_PMAX = PERIOD_W'(PERIOD_MAX);
    localparam logic [PERIOD_W-1:0] c_PMIN = PERIOD_W'(PERIOD_MIN);
    localparam logic [PERIOD_W-1:0] c_ONE  = PERIOD_W'(1);
    localparam logic [STEP_W-1:0]   c_LAST = STEP_W'(STEPS - 1);
    localparam logic [STEP_W-1:0]   c_SONE = STEP_W'(1);
    localparam logic [c_HOLD_W-1:0] c_HOLD = c_HOLD_W'(ROUND_HOLD);
    localparam logic [c_HOLD_W-1:0] c_HONE = c_HOLD_W'(1);

    logic [1:0]          r_state,   w_stateN;
    logic [STEP_W-1:0]   r_step,    w_stepN;
    logic [PERIOD_W-1:0] r_period,  w_periodN;
    logic [PERIOD_W-1:0] r_remain,  w_remainN;
    logic [c_HOLD_W-1:0] r_holdCnt, w_holdN;
    logic                r_lastDec, w_lastDecN;   // 1 = last request was DEC
    logic                r_dir,     w_dirN;

    logic                w_tick;
    logic                w_atEnd;
    logic                w_bnd;
    logic [STEP_W-1:0]   w_stepAdv;
    logic [PERIOD_W:0]   w_delta;
    logic [PERIOD_W:0]   w_sumUp;
    logic [PERIOD_W:0]   w_diffDn;
    logic [PERIOD_W-1:0] w_slower;
    logic [PERIOD_W-1:0] w_faster;

    // Step timer expiry, step successor and round-boundary detection
    always_comb begin
        w_tick    = (r_state != c_ST_IDLE) && (r_remain == c_ONE);
        w_atEnd   = r_dir ? (r_step == '0) : (r_step == c_LAST);
        w_stepAdv = r_dir ? ((r_step == '0) ? c_LAST : r_step - c_SONE)
                          : ((r_step == c_LAST) ? '0 : r_step + c_SONE);
        w_bnd     = w_tick && w_atEnd &&
                    ((r_state == c_ST_RUN) || (r_state == c_ST_BRAKE));
    end

    // Clamped slower/faster candidate periods, one bit wider than the period
    always_comb begin
        w_delta = {1'b0, r_period >> ACC_SHIFT};
        if (w_delta == '0) begin
            w_delta = {{PERIOD_W{1'b0}}, 1'b1};
        end
        w_sumUp  = {1'b0, r_period} + w_delta;
        w_diffDn = {1'b0, r_period} - w_delta;
        w_slower = (w_sumUp > {1'b0, c_PMAX}) ? c_PMAX : w_sumUp[PERIOD_W-1:0];
        w_faster = (w_diffDn[PERIOD_W] || (w_diffDn < {1'b0, c_PMIN}))
                   ? c_PMIN : w_diffDn[PERIOD_W-1:0];
    end

    // Next-state and datapath update for the sequencer
    always_comb begin
        w_stateN   = r_state;
        w_stepN    = r_step;
        w_periodN  = r_period;
        w_remainN  = r_remain;
        w_holdN    = r_holdCnt;
        w_lastDecN = r_lastDec;
        w_dirN     = r_dir;
        if (forceStopI) begin
            w_stateN   = c_ST_IDLE;
            w_stepN    = '0;
            w_periodN  = c_PMAX;
            w_remainN  = c_PMAX;
            w_holdN    = c_HOLD;
            w_lastDecN = 1'b0;
        end else begin
            if (r_state != c_ST_IDLE) begin
                w_remainN = r_remain - c_ONE;
                if (w_tick) begin
                    w_stepN = w_stepAdv;
                end
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (startI) begin
                        w_stateN  = c_ST_ALIGN;
                        w_remainN = c_PMAX;
                        w_dirN    = invRotateI;
                    end
                end
                c_ST_ALIGN: begin
                    if (w_tick) begin
                        w_stateN = c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (w_bnd) begin
                        // Direction may only flip while at standstill speed
                        if (r_period == c_PMAX) begin
                            w_dirN = invRotateI;
                        end
                        if (speedINCi) begin
                            if (r_lastDec) begin
                                w_lastDecN = 1'b0;
                                w_holdN    = c_HOLD;
                            end else if (r_holdCnt != '0) begin
                                w_holdN = r_holdCnt - c_HONE;
                            end else begin
                                w_holdN   = c_HOLD;
                                w_periodN = w_faster;
                            end
                        end else if (speedDECi) begin
                            if (!r_lastDec) begin
                                w_lastDecN = 1'b1;
                                w_holdN    = c_HOLD;
                            end else if (r_holdCnt != '0) begin
                                w_holdN = r_holdCnt - c_HONE;
                            end else begin
                                w_holdN   = c_HOLD;
                                w_periodN = w_slower;
                            end
                        end else begin
                            w_holdN = c_HOLD;
                        end
                    end
                    if (!startI) begin
                        w_stateN = c_ST_BRAKE;
                    end
                end
                c_ST_BRAKE: begin
                    if (startI) begin
                        w_stateN = c_ST_RUN;
                        w_holdN  = c_HOLD;
                    end else if (w_bnd) begin
                        w_periodN = w_slower;
                        if (w_slower == c_PMAX) begin
                            w_stateN = c_ST_IDLE;
                            w_stepN  = '0;
                        end
                    end
                end
                default: begin
                    w_stateN = c_ST_IDLE;
                end
            endcase
            // A fresh step always runs for the period written this same cycle
            if (w_tick) begin
                w_remainN = w_periodN;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            r_state   <= c_ST_IDLE;
            r_step    <= '0;
            r_period  <= c_PMAX;
            r_remain  <= c_PMAX;
            r_holdCnt <= c_HOLD;
            r_lastDec <= 1'b0;
            r_dir     <= 1'b0;
        end else begin
            r_state   <= w_stateN;
            r_step    <= w_stepN;
            r_period  <= w_periodN;
            r_remain  <= w_remainN;
            r_holdCnt <= w_holdN;
            r_lastDec <= w_lastDecN;
            r_dir     <= w_dirN;
        end
    end

    assign stepStbO  = w_tick & ~forceStopI;
    assign roundStbO = w_bnd & ~forceStopI;
    assign stepO     = r_step;
    assign periodO   = r_period;
    assign stateO    = r_state;
    assign workingO  = (r_state != c_ST_IDLE);
    assign dirO      = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_m3_stepseq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_m3_stepseq
//  Description : Self-checking bench for m3_stepseq: vector table for ramp,
//                clamp and request-switch behaviour plus directed sequences
//                for align, brake, reverse, force stop and async reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_m3_stepseq;

    localparam int c_PW = 22;

    logic clkI = 1'b0;
    logic rstI;

    logic aStart, aForce, aInv, aInc, aDec;
    logic [3:0] aStep;
    logic aStepStb, aRoundStb, aWorking, aDir;
    logic [c_PW-1:0] aPeriod;
    logic [1:0] aState;

    logic bStart, bForce, bInv, bInc, bDec;
    logic [3:0] bStep;
    logic bStepStb, bRoundStb, bWorking, bDir;
    logic [c_PW-1:0] bPeriod;
    logic [1:0] bState;

    logic cStart, cForce, cInv, cInc, cDec;
    logic [0:0] cStep;
    logic cStepStb, cRoundStb, cWorking, cDir;
    logic [c_PW-1:0] cPeriod;
    logic [1:0] cState;

    int nTests = 0;
    int nFail  = 0;
    int eStep;
    bit eRev;

    typedef struct {
        int   inst;       // 1 = clamp instance, 2 = small-period instance
        logic inc;
        logic dec;
        int   nBnd;       // round boundaries to let pass
        int   expPeriod;
    } vec_t;
    vec_t vecs [0:14];

    always #5 clkI = ~clkI;

    m3_stepseq #(.STEPS(12), .STEP_W(4), .PERIOD_W(c_PW), .PERIOD_MAX(300),
                 .PERIOD_MIN(40), .ACC_SHIFT(4), .ROUND_HOLD(3)) u_dutA (
        .clkI(clkI), .rstI(rstI), .startI(aStart), .forceStopI(aForce),
        .invRotateI(aInv), .speedINCi(aInc), .speedDECi(aDec),
        .stepO(aStep), .stepStbO(aStepStb), .roundStbO(aRoundStb),
        .periodO(aPeriod), .stateO(aState), .workingO(aWorking), .dirO(aDir));

    m3_stepseq #(.STEPS(12), .STEP_W(4), .PERIOD_W(c_PW), .PERIOD_MAX(42),
                 .PERIOD_MIN(40), .ACC_SHIFT(4), .ROUND_HOLD(3)) u_dutB (
        .clkI(clkI), .rstI(rstI), .startI(bStart), .forceStopI(bForce),
        .invRotateI(bInv), .speedINCi(bInc), .speedDECi(bDec),
        .stepO(bStep), .stepStbO(bStepStb), .roundStbO(bRoundStb),
        .periodO(bPeriod), .stateO(bState), .workingO(bWorking), .dirO(bDir));

    m3_stepseq #(.STEPS(2), .STEP_W(1), .PERIOD_W(c_PW), .PERIOD_MAX(12),
                 .PERIOD_MIN(8), .ACC_SHIFT(4), .ROUND_HOLD(0)) u_dutC (
        .clkI(clkI), .rstI(rstI), .startI(cStart), .forceStopI(cForce),
        .invRotateI(cInv), .speedINCi(cInc), .speedDECi(cDec),
        .stepO(cStep), .stepStbO(cStepStb), .roundStbO(cRoundStb),
        .periodO(cPeriod), .stateO(cState), .workingO(cWorking), .dirO(cDir));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clkI);
        #1;
    endtask

    // Wait until instance A shows a step strobe; n = cycles waited
    task automatic waitStbA(input int maxc, output int n);
        n = 0;
        while (aStepStb !== 1'b1 && n < maxc) begin
            tick(1);
            n++;
        end
        if (aStepStb !== 1'b1) begin
            nTests++;
            nFail++;
            $display("FAIL stepStb timeout: got none after %0d cycles, expected a strobe", n);
        end
    endtask

    // Pass cnt step strobes of instance A, checking interval, round flag and step
    task automatic stepsA(input int cnt, input int interval);
        int n;
        for (int i = 0; i < cnt; i++) begin
            waitStbA(1000, n);
            if (interval != 0) chk("A step interval", n + 1, interval);
            chk("A roundStb", aRoundStb, eRev ? (eStep == 0) : (eStep == 11));
            if (eRev) eStep = (eStep == 0) ? 11 : eStep - 1;
            else      eStep = (eStep == 11) ? 0 : eStep + 1;
            tick(1);
            chk("A stepO", aStep, eStep);
        end
    endtask

    // Wait for one round strobe of instance B or C, then step past that edge
    task automatic waitRound(input int inst);
        int n = 0;
        while (((inst == 1) ? bRoundStb : cRoundStb) !== 1'b1 && n < 5000) begin
            tick(1);
            n++;
        end
        if (((inst == 1) ? bRoundStb : cRoundStb) !== 1'b1) begin
            nTests++;
            nFail++;
            $display("FAIL roundStb timeout inst %0d: got none, expected a strobe", inst);
        end
        tick(1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0]  = '{1, 1'b1, 1'b0, 3, 42};   // hold rounds only
        vecs[1]  = '{1, 1'b1, 1'b0, 1, 40};   // 42 - 2
        vecs[2]  = '{1, 1'b1, 1'b0, 3, 40};
        vecs[3]  = '{1, 1'b1, 1'b0, 1, 40};   // 38 clamps to 40
        vecs[4]  = '{1, 1'b0, 1'b1, 1, 40};   // switch INC->DEC, hold reload
        vecs[5]  = '{1, 1'b0, 1'b1, 3, 40};
        vecs[6]  = '{1, 1'b0, 1'b1, 1, 42};   // 40 + 2 at boundary 5
        vecs[7]  = '{1, 1'b1, 1'b1, 1, 42};   // INC wins, switch only
        vecs[8]  = '{1, 1'b1, 1'b1, 3, 42};
        vecs[9]  = '{1, 1'b1, 1'b1, 1, 40};
        vecs[10] = '{2, 1'b1, 1'b0, 1, 11};   // d forced to 1, no hold
        vecs[11] = '{2, 1'b1, 1'b0, 1, 10};
        vecs[12] = '{2, 1'b1, 1'b0, 1, 9};
        vecs[13] = '{2, 1'b1, 1'b0, 1, 8};
        vecs[14] = '{2, 1'b1, 1'b0, 1, 8};

        rstI = 1'b1;
        {aStart, aForce, aInv, aInc, aDec} = '0;
        {bStart, bForce, bInv, bInc, bDec} = '0;
        {cStart, cForce, cInv, cInc, cDec} = '0;
        tick(3);
        chk("reset stateO", aState, 0);
        chk("reset stepO", aStep, 0);
        chk("reset periodO", aPeriod, 300);
        chk("reset stepStbO", aStepStb, 0);
        chk("reset roundStbO", aRoundStb, 0);
        chk("reset workingO", aWorking, 0);
        chk("reset dirO", aDir, 0);
        rstI = 1'b0;
        tick(2);
        chk("idle hold stateO", aState, 0);

        // ---- vector table on the clamp and small-period instances ----
        bStart = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].inst == 1) begin
                bInc = vecs[i].inc;
                bDec = vecs[i].dec;
            end else begin
                cStart = 1'b1;
                cInc   = vecs[i].inc;
                cDec   = vecs[i].dec;
            end
            for (int k = 0; k < vecs[i].nBnd; k++) waitRound(vecs[i].inst);
            chk($sformatf("vec%0d periodO", i),
                (vecs[i].inst == 1) ? bPeriod : cPeriod, vecs[i].expPeriod);
            chk($sformatf("vec%0d stateO", i),
                (vecs[i].inst == 1) ? bState : cState, 2);
        end
        // Force stop both on the same cycle; strobes must be masked
        bForce = 1'b1;
        cForce = 1'b1;
        #1;
        chk("B forced stepStbO", bStepStb, 0);
        chk("C forced stepStbO", cStepStb, 0);
        tick(1);
        chk("B forced stateO", bState, 0);
        chk("B forced periodO", bPeriod, 42);
        chk("B forced stepO", bStep, 0);
        chk("B workingO", bWorking, 0);
        chk("B dirO", bDir, 0);
        chk("B roundStbO", bRoundStb, 0);
        chk("C forced stateO", cState, 0);
        chk("C forced periodO", cPeriod, 12);
        chk("C forced stepO", cStep, 0);
        chk("C workingO", cWorking, 0);
        chk("C dirO", cDir, 0);
        chk("C roundStbO", cRoundStb, 0);
        {bStart, bForce, bInc, bDec} = '0;
        {cStart, cForce, cInc, cDec} = '0;

        // ---- A: forward start, align, accelerate, brake ----
        aInc   = 1'b1;
        aStart = 1'b1;
        tick(1);
        chk("A align stateO", aState, 1);
        chk("A align stepO", aStep, 0);
        chk("A align workingO", aWorking, 1);
        waitStbA(1000, n);
        chk("A align length", n + 1, 300);
        chk("A align roundStbO", aRoundStb, 0);
        tick(1);
        chk("A run stateO", aState, 2);
        chk("A run first stepO", aStep, 1);
        eStep = 1;
        eRev  = 1'b0;
        stepsA(11, 300);
        chk("A bnd1 periodO", aPeriod, 300);
        stepsA(24, 300);
        chk("A bnd3 periodO", aPeriod, 300);
        stepsA(12, 300);
        chk("A bnd4 periodO", aPeriod, 282);
        stepsA(1, 282);
        aStart = 1'b0;
        aInc   = 1'b0;
        tick(1);
        chk("A brake stateO", aState, 3);
        stepsA(1, 0);
        stepsA(10, 282);
        chk("A brake bnd1 periodO", aPeriod, 299);
        chk("A brake bnd1 stateO", aState, 3);
        aStart = 1'b1;
        tick(1);
        chk("A rerun stateO", aState, 2);
        chk("A rerun periodO", aPeriod, 299);
        aStart = 1'b0;
        tick(1);
        chk("A rebrake stateO", aState, 3);
        stepsA(1, 0);
        stepsA(11, 299);
        chk("A stopped stateO", aState, 0);
        chk("A stopped periodO", aPeriod, 300);
        chk("A stopped workingO", aWorking, 0);
        tick(5);
        chk("A idle stepStbO", aStepStb, 0);
        chk("A idle stepO", aStep, 0);

        // ---- A: reverse run, direction lock away from max period, force stop ----
        aInv   = 1'b1;
        aInc   = 1'b1;
        aStart = 1'b1;
        tick(1);
        chk("A rev align stateO", aState, 1);
        chk("A rev dirO", aDir, 1);
        waitStbA(1000, n);
        tick(1);
        chk("A rev first stepO", aStep, 11);
        eStep = 11;
        eRev  = 1'b1;
        stepsA(12, 300);
        stepsA(36, 300);
        chk("A rev bnd4 periodO", aPeriod, 282);
        aInv = 1'b0;
        stepsA(48, 282);
        chk("A rev bnd8 periodO", aPeriod, 265);
        chk("A rev dir locked", aDir, 1);
        stepsA(1, 265);
        waitStbA(1000, n);
        aForce = 1'b1;
        #1;
        chk("A force stepStbO", aStepStb, 0);
        chk("A force roundStbO", aRoundStb, 0);
        tick(1);
        chk("A force stateO", aState, 0);
        chk("A force periodO", aPeriod, 300);
        chk("A force stepO", aStep, 0);
        chk("A force dirO held", aDir, 1);
        aForce = 1'b0;
        aStart = 1'b0;
        aInc   = 1'b0;
        tick(1);
        chk("A post-force stateO", aState, 0);

        // ---- A: direction change at max period, then async reset mid-step ----
        aStart = 1'b1;
        tick(1);
        chk("A fwd dirO", aDir, 0);
        waitStbA(1000, n);
        tick(1);
        eStep = 1;
        eRev  = 1'b0;
        aInv  = 1'b1;
        stepsA(11, 300);
        chk("A dir flip at max", aDir, 1);
        eRev = 1'b1;
        stepsA(1, 300);
        #3;
        rstI = 1'b1;
        #1;
        chk("A async rst stateO", aState, 0);
        chk("A async rst stepO", aStep, 0);
        chk("A async rst periodO", aPeriod, 300);
        chk("A async rst workingO", aWorking, 0);
        chk("A async rst dirO", aDir, 0);
        chk("A async rst stepStbO", aStepStb, 0);
        aStart = 1'b0;
        aInv   = 1'b0;
        tick(1);
        rstI = 1'b0;
        tick(1);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
